multi_rf_renamer: RTL and testbench



---
 rtl/multi_rf_renamer.sv | 178 +++++++++++++++++
 tb/tb_multi_rf_renamer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_rf_renamer.sv
// multi_rf_renamer: per-file speculative rename tables and free lists with a shared in-use list,
// self-initialising after reset and restoring the tables youngest-first on flush.
module multi_rf_renamer #(
    parameter int NUM_RF    = 2,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int INFLIGHT  = 32,
    parameter int NUM_SRC   = 3,
    parameter int WB_GROUPS = 4,
    localparam int WBG_W = (WB_GROUPS > 1) ? $clog2(WB_GROUPS) : 1,
    localparam int AW    = $clog2(ARCH_REGS),
    localparam int PW    = $clog2(PHYS_REGS),
    localparam int RW    = (NUM_RF > 1) ? $clog2(NUM_RF) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rename_req_i,
    input  logic [RW-1:0]                    rename_rf_i,
    input  logic [AW-1:0]                    rename_rd_i,
    input  logic [WBG_W-1:0]                 rename_wb_group_i,
    output logic                             rename_ready_o,
    output logic [PW-1:0]                    rename_phys_rd_o,
    input  logic [NUM_SRC-1:0][RW-1:0]       src_rf_i,
    input  logic [NUM_SRC-1:0][AW-1:0]       src_rs_i,
    output logic [NUM_SRC-1:0][PW-1:0]       src_phys_o,
    output logic [NUM_SRC-1:0][WBG_W-1:0]    src_wb_group_o,
    input  logic                             retire_valid_i,
    input  logic                             flush_req_i,
    output logic                             flush_done_o,
    output logic                             init_done_o
);
    localparam int FD  = PHYS_REGS - ARCH_REGS;
    localparam int N   = (ARCH_REGS > FD) ? ARCH_REGS : FD;
    localparam int FPW = (FD > 1) ? $clog2(FD) : 1;
    localparam int FCW = $clog2(FD) + 1;
    localparam int IPW = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
    localparam int ICW = $clog2(INFLIGHT) + 1;
    localparam int CW  = $clog2(N + 1);
    localparam int MW  = PW + WBG_W;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_WALK} state_t;
    typedef struct packed {
        logic [RW-1:0] rf;
        logic [AW-1:0] rd;
        logic [PW-1:0] spec;
        logic [MW-1:0] prev;
    } iu_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  i_q;
    logic           init_done_q;
    logic [MW-1:0]  tbl_q [NUM_RF][ARCH_REGS];
    logic [PW-1:0]  fmem_q [NUM_RF][FD];
    logic [FPW-1:0] fhd_q [NUM_RF];
    logic [FPW-1:0] ftl_q [NUM_RF];
    logic [FCW-1:0] fcnt_q [NUM_RF];
    iu_t            imem_q [INFLIGHT];
    logic [IPW-1:0] ihd_q, itl_q, itl_prev;
    logic [ICW-1:0] icnt_q;

    logic           run, walk, skip, fire, alloc, retire, wb_pop, init_fill, init_tbl, free_ovf;
    logic [PW-1:0]  alloc_p;
    iu_t            tail_e;
    logic           tbl_we;
    logic [RW-1:0]  tbl_rf;
    logic [AW-1:0]  tbl_rd;
    logic [MW-1:0]  tbl_wd;
    logic           fpush [NUM_RF];
    logic           fpop [NUM_RF];
    logic [PW-1:0]  fpush_d [NUM_RF];

    function automatic logic [FPW-1:0] fnext(input logic [FPW-1:0] p);
        return (p == FPW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IPW-1:0] inext(input logic [IPW-1:0] p);
        return (p == IPW'(INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign run       = state_q == S_RUN;
    assign walk      = state_q == S_WALK;
    assign init_fill = state_q == S_INIT && i_q < CW'(FD);
    assign init_tbl  = state_q == S_INIT && i_q < CW'(ARCH_REGS);
    assign skip      = rename_rf_i == '0 && rename_rd_i == '0;
    // flush wins over rename and retire in the same cycle
    assign rename_ready_o = run && init_done_q && !flush_req_i &&
                            fcnt_q[rename_rf_i] != '0 && icnt_q != ICW'(INFLIGHT);
    assign fire      = rename_req_i && rename_ready_o;
    assign alloc     = fire && !skip;
    assign retire    = run && !flush_req_i && retire_valid_i && icnt_q != '0;
    assign wb_pop    = walk && icnt_q != '0;
    assign itl_prev  = (itl_q == '0) ? IPW'(INFLIGHT - 1) : itl_q - 1'b1;
    assign tail_e    = imem_q[itl_prev];
    assign alloc_p   = fmem_q[rename_rf_i][fhd_q[rename_rf_i]];
    assign rename_phys_rd_o = alloc ? alloc_p : '0;
    assign flush_done_o     = walk && icnt_q == '0;
    assign init_done_o      = init_done_q;

    assign tbl_we = alloc || wb_pop;
    assign tbl_rf = wb_pop ? tail_e.rf : rename_rf_i;
    assign tbl_rd = wb_pop ? tail_e.rd : rename_rd_i;
    assign tbl_wd = wb_pop ? tail_e.prev : {alloc_p, rename_wb_group_i};

    always_comb begin
        free_ovf = 1'b0;
        for (int r = 0; r < NUM_RF; r++) begin
            fpop[r]    = alloc && rename_rf_i == RW'(r);
            fpush[r]   = init_fill || (retire && imem_q[ihd_q].rf == RW'(r)) ||
                         (wb_pop && tail_e.rf == RW'(r));
            fpush_d[r] = init_fill ? PW'(ARCH_REGS) + PW'(i_q) :
                         retire ? imem_q[ihd_q].prev[MW-1 -: PW] : tail_e.spec;
            free_ovf   = free_ovf || (fpush[r] && fcnt_q[r] == FCW'(FD));
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            src_phys_o[s]     = (src_rf_i[s] == '0 && src_rs_i[s] == '0) ? '0 :
                                tbl_q[src_rf_i[s]][src_rs_i[s]][MW-1 -: PW];
            src_wb_group_o[s] = (src_rf_i[s] == '0 && src_rs_i[s] == '0) ? '0 :
                                tbl_q[src_rf_i[s]][src_rs_i[s]][WBG_W-1:0];
        end
    end

    assign state_d = (state_q == S_INIT && i_q == CW'(N - 1)) ? S_RUN :
                     (run && flush_req_i) ? S_WALK :
                     flush_done_o ? S_RUN : state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            i_q         <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) i_q <= i_q + 1'b1;
            if (state_q == S_INIT && i_q == CW'(N - 1)) init_done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_RF; r++) begin
                fhd_q[r]  <= '0;
                ftl_q[r]  <= '0;
                fcnt_q[r] <= '0;
            end
            ihd_q  <= '0;
            itl_q  <= '0;
            icnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_RF; r++) begin
                if (fpush[r]) ftl_q[r] <= fnext(ftl_q[r]);
                if (fpop[r]) fhd_q[r] <= fnext(fhd_q[r]);
                fcnt_q[r] <= fcnt_q[r] + FCW'(fpush[r]) - FCW'(fpop[r]);
            end
            if (alloc) itl_q <= inext(itl_q);
            else if (wb_pop) itl_q <= itl_prev;
            if (retire) ihd_q <= inext(ihd_q);
            icnt_q <= icnt_q + ICW'(alloc) - ICW'(retire || wb_pop);
        end
    end

    // storage arrays carry no reset; INIT fills everything that is later read
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_RF; r++) begin
            if (fpush[r]) fmem_q[r][ftl_q[r]] <= fpush_d[r];
            if (init_tbl) tbl_q[r][i_q[AW-1:0]] <= {PW'(i_q), {WBG_W{1'b0}}};
            else if (tbl_we && tbl_rf == RW'(r)) tbl_q[r][tbl_rd] <= tbl_wd;
        end
        if (alloc) imem_q[itl_q] <= '{rf: rename_rf_i, rd: rename_rd_i, spec: alloc_p,
                                      prev: tbl_q[rename_rf_i][rename_rd_i]};
    end

    a_retire_legal: assert property (@(posedge clk) disable iff (!rst_n)
        retire_valid_i |-> (run && icnt_q != '0));
    a_free_no_ovf: assert property (@(posedge clk) disable iff (!rst_n) !free_ovf);
endmodule

// File: tb/tb_multi_rf_renamer.sv
// tb_multi_rf_renamer: random and directed stimulus against a queue-based reference model.
module tb_multi_rf_renamer;
    localparam int NUM_RF = 2, ARCH_REGS = 32, PHYS_REGS = 64, INFLIGHT = 32, NUM_SRC = 3, WB_GROUPS = 4;
    localparam int WBG_W = 2, AW = 5, PW = 6, RW = 1;
    localparam int N = 32;

    logic clk, rst_n;
    logic rename_req_i, retire_valid_i, flush_req_i;
    logic [RW-1:0] rename_rf_i;
    logic [AW-1:0] rename_rd_i;
    logic [WBG_W-1:0] rename_wb_group_i;
    logic rename_ready_o, flush_done_o, init_done_o;
    logic [PW-1:0] rename_phys_rd_o;
    logic [NUM_SRC-1:0][RW-1:0] src_rf_i;
    logic [NUM_SRC-1:0][AW-1:0] src_rs_i;
    logic [NUM_SRC-1:0][PW-1:0] src_phys_o;
    logic [NUM_SRC-1:0][WBG_W-1:0] src_wb_group_o;

    multi_rf_renamer #(.NUM_RF(NUM_RF), .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS),
                       .INFLIGHT(INFLIGHT), .NUM_SRC(NUM_SRC), .WB_GROUPS(WB_GROUPS)) dut (
        .clk(clk), .rst_n(rst_n),
        .rename_req_i(rename_req_i), .rename_rf_i(rename_rf_i), .rename_rd_i(rename_rd_i),
        .rename_wb_group_i(rename_wb_group_i), .rename_ready_o(rename_ready_o),
        .rename_phys_rd_o(rename_phys_rd_o), .src_rf_i(src_rf_i), .src_rs_i(src_rs_i),
        .src_phys_o(src_phys_o), .src_wb_group_o(src_wb_group_o),
        .retire_valid_i(retire_valid_i), .flush_req_i(flush_req_i),
        .flush_done_o(flush_done_o), .init_done_o(init_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0, errors = 0;

    task automatic check(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {int rf; int rd; int spec; int pp; int pg;} ent_t;
    int map_p [NUM_RF][ARCH_REGS];
    int map_g [NUM_RF][ARCH_REGS];
    int fq [NUM_RF][$];
    ent_t iq [$];
    int mode, icnt;
    bit initd;
    bit c_fire, c_skip, c_ret, c_fl;
    int c_rf, c_rd, c_g;

    task automatic model_reset();
        mode = 0; icnt = 0; initd = 0;
        iq.delete();
        for (int r = 0; r < NUM_RF; r++) fq[r].delete();
    endtask

    task automatic rand_src();
        for (int s = 0; s < NUM_SRC; s++) begin
            src_rf_i[s] = RW'($urandom_range(NUM_RF - 1));
            src_rs_i[s] = AW'($urandom_range(ARCH_REGS - 1));
        end
    endtask

    task automatic apply(input bit req, input int rf, input int rd, input int g, input bit ret, input bit fl);
        bit ready;
        rename_req_i = req; rename_rf_i = RW'(rf); rename_rd_i = AW'(rd);
        rename_wb_group_i = WBG_W'(g); retire_valid_i = ret; flush_req_i = fl;
        #1;
        ready = mode == 1 && initd && fq[rf].size() > 0 && iq.size() < INFLIGHT && !fl;
        c_fire = req && ready; c_skip = rf == 0 && rd == 0;
        c_rf = rf; c_rd = rd; c_g = g; c_ret = ret; c_fl = fl;
        check("ready", int'(rename_ready_o), int'(ready));
        check("phys_rd", int'(rename_phys_rd_o), (c_fire && !c_skip) ? fq[rf][0] : 0);
        check("flush_done", int'(flush_done_o), int'(mode == 2 && iq.size() == 0));
        check("init_done", int'(init_done_o), int'(initd));
        if (mode != 0)
            for (int s = 0; s < NUM_SRC; s++) begin
                int r = int'(src_rf_i[s]), a = int'(src_rs_i[s]);
                bit z = r == 0 && a == 0;
                check("src_phys", int'(src_phys_o[s]), z ? 0 : map_p[r][a]);
                check("src_wbg", int'(src_wb_group_o[s]), z ? 0 : map_g[r][a]);
            end
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (mode == 0) begin
            icnt++;
            if (icnt == N) begin
                for (int r = 0; r < NUM_RF; r++) begin
                    for (int a = 0; a < ARCH_REGS; a++) begin map_p[r][a] = a; map_g[r][a] = 0; end
                    for (int p = ARCH_REGS; p < PHYS_REGS; p++) fq[r].push_back(p);
                end
                mode = 1; initd = 1;
            end
        end else if (mode == 1) begin
            if (c_fl) mode = 2;
            else begin
                if (c_ret && iq.size() > 0) begin e = iq.pop_front(); fq[e.rf].push_back(e.pp); end
                if (c_fire && !c_skip) begin
                    e.rf = c_rf; e.rd = c_rd; e.spec = fq[c_rf].pop_front();
                    e.pp = map_p[c_rf][c_rd]; e.pg = map_g[c_rf][c_rd];
                    iq.push_back(e);
                    map_p[c_rf][c_rd] = e.spec; map_g[c_rf][c_rd] = c_g;
                end
            end
        end else begin
            if (iq.size() == 0) mode = 1;
            else begin
                e = iq.pop_back();
                map_p[e.rf][e.rd] = e.pp; map_g[e.rf][e.rd] = e.pg;
                fq[e.rf].push_back(e.spec);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        apply(0, 0, 1, 0, 0, 0);
        tick();
    endtask

    task automatic init_seq();
        for (int k = 0; k < N; k++) begin rand_src(); idle(); end
    endtask

    task automatic flush_all();
        apply(0, 0, 1, 0, 0, 1);
        tick();
        for (int k = 0; k < 2 * INFLIGHT && mode == 2; k++) begin rand_src(); idle(); end
    endtask

    task automatic random_phase(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            bit fl = $urandom_range(99) < 3;
            bit ret = mode == 1 && iq.size() > 0 && $urandom_range(99) < 45;
            int rf = $urandom_range(NUM_RF - 1);
            int rd = ($urandom_range(7) == 0) ? 0 : $urandom_range(ARCH_REGS - 1);
            rand_src();
            apply($urandom_range(99) < 70, rf, rd, $urandom_range(WB_GROUPS - 1), ret, fl);
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, int'(rename_ready_o), 0);
        check({tag, "_phys"}, int'(rename_phys_rd_o), 0);
        check({tag, "_fdone"}, int'(flush_done_o), 0);
        check({tag, "_idone"}, int'(init_done_o), 0);
    endtask

    initial begin
        rst_n = 0; rename_req_i = 0; rename_rf_i = '0; rename_rd_i = '0; rename_wb_group_i = '0;
        retire_valid_i = 0; flush_req_i = 0; src_rf_i = '0; src_rs_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1;
        init_seq();
        src_rf_i[0] = 1; src_rs_i[0] = 5;
        apply(0, 0, 1, 0, 0, 0);
        check("init_done_rise", int'(init_done_o), 1);
        check("init_map_f1r5", int'(src_phys_o[0]), 5);
        tick();
        apply(1, 0, 0, 2, 0, 0);
        check("x0_phys", int'(rename_phys_rd_o), 0);
        tick();
        for (int k = 0; k < 32; k++) begin
            rand_src();
            apply(1, 0, 1, k % WB_GROUPS, 0, 0);
            check("exhaust_phys", int'(rename_phys_rd_o), 32 + k);
            tick();
        end
        apply(1, 0, 1, 0, 0, 0);
        check("exhaust_stall", int'(rename_ready_o), 0);
        tick();
        apply(0, 0, 1, 0, 1, 0);
        tick();
        apply(1, 0, 1, 0, 1, 0);
        check("retire_ready", int'(rename_ready_o), 1);
        check("retire_reuse", int'(rename_phys_rd_o), 1);
        tick();
        src_rf_i[0] = 0; src_rs_i[0] = 3;
        apply(1, 0, 3, 1, 0, 0);
        check("same_cycle_old", int'(src_phys_o[0]), 3);
        check("same_cycle_alloc", int'(rename_phys_rd_o), 32);
        tick();
        apply(0, 0, 1, 0, 0, 0);
        check("next_cycle_new", int'(src_phys_o[0]), 32);
        tick();
        apply(1, 0, 5, 1, 0, 1);
        check("flush_blocks_rename", int'(rename_ready_o), 0);
        tick();
        for (int k = 0; k < 2 * INFLIGHT && mode == 2; k++) begin rand_src(); idle(); end

        random_phase(3000);

        flush_all();
        for (int k = 0; k < 3; k++) begin rand_src(); apply(1, 1, 2, k, 0, 0); tick(); end
        apply(0, 0, 1, 0, 0, 1);
        tick();
        rand_src();
        idle();
        rst_n = 0;
        #1;
        check_reset_outputs("midwalk");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        init_seq();

        apply(1, 0, 4, 1, 0, 0); check("fl_r4a", int'(rename_phys_rd_o), 32); tick();
        apply(1, 0, 4, 2, 0, 0); check("fl_r4b", int'(rename_phys_rd_o), 33); tick();
        apply(1, 1, 7, 3, 0, 0); check("fl_f1r7", int'(rename_phys_rd_o), 32); tick();
        apply(0, 0, 1, 0, 0, 1); tick();
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 1, 0, 0, 0);
            check("walk_busy", int'(flush_done_o), 0);
            tick();
        end
        apply(0, 0, 1, 0, 0, 0);
        check("walk_done", int'(flush_done_o), 1);
        tick();
        src_rf_i[0] = 0; src_rs_i[0] = 4; src_rf_i[1] = 1; src_rs_i[1] = 7;
        apply(1, 0, 9, 0, 0, 0);
        check("restore_r4", int'(src_phys_o[0]), 4);
        check("restore_f1r7", int'(src_phys_o[1]), 7);
        check("reuse_f0", int'(rename_phys_rd_o), 34);
        tick();
        apply(1, 1, 9, 0, 0, 0);
        check("reuse_f1", int'(rename_phys_rd_o), 33);
        tick();
        random_phase(500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
